dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and sequencer for the single-port data memory. It shares the memory's one `addr`/`writeData`/`writeEnable`/`read` port between the CPU data port and an auxiliary requester (loader/debug DMA). It uses round-robin arbitration and a req/ack handshake per requester. It also rejects misaligned or out-of-range word accesses before they reach the memory array.

## Interface
Parameters:
- `DEPTH_WORDS`, 64: number of 32-bit words in the attached memory. Legal byte addresses are 0 .. 4*DEPTH_WORDS-4.
- `DATA_W`, 32: data width.

Ports:
- `clk`  in  1  single clock; all state changes on posedge.
- `reset`  in  1  reset is synchronous and active-high.
- `cpu_req`  in  1  CPU access request; held with `cpu_we`/`cpu_addr`/`cpu_wdata` stable until `cpu_ack`.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  32  byte address.
- `cpu_wdata`  in  DATA_W  write data.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `cpu_err`  out  1  valid with `cpu_ack`; 1 = access rejected.
- `cpu_rdata`  out  DATA_W  read data; valid from `cpu_ack` until the next CPU read completes.
- `aux_req`, `aux_we`, `aux_addr`, `aux_wdata`, `aux_ack`, `aux_err`, `aux_rdata`: identical set for the auxiliary requester.
- `mem_addr`  out  32  to memory `addr`.
- `mem_writeData`  out  DATA_W  to memory `writeData`.
- `mem_writeEnable`  out  1  to memory `writeEnable`.
- `mem_read`  in  DATA_W  from memory `read` (combinational in `mem_addr`).

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- IDLE: sample the requests.
  - None asserted: stay in IDLE.
  - Exactly one asserted: grant it.
  - Both asserted: grant the requester not served last. The `last` pointer resets to AUX, so the CPU wins the first tie.
  - On grant: latch the winner's id, `we`, `addr`, `wdata`, and `ok` into registers, then go to ACCESS.
  - `ok` = (`addr[1:0]`==0) and (`addr[31:2]` < DEPTH_WORDS).
- ACCESS (exactly one cycle):
  - `mem_addr`/`mem_writeData` driven from the latched registers.
  - `mem_writeEnable` = `we_q & ok_q & ~reset`; the write commits at the posedge ending ACCESS.
  - For a read with `ok_q`, the winner's `rdata` register captures `mem_read` at that edge.
  - Update `last` to the winner and go to RESP.
- RESP (exactly one cycle):
  - Winner's `ack`=1 and `err`=~`ok_q`; go to IDLE.
  - The loser's ack/err stay 0.
- `rdata` changes only on successful reads. Writes and rejected accesses leave it unchanged.
- A rejected access (misaligned or out of range) never asserts `mem_writeEnable`, but still takes the full ACCESS/RESP sequence.
- Requester rule: deassert `req` at the edge ending the ack cycle. A `req` still high in IDLE is a new request.
- A request withdrawn before grant is ignored. A request withdrawn after grant still completes and is acked.

## Timing
- Reset values:
  - State IDLE, `last`=AUX.
  - `cpu_ack`/`aux_ack`/`cpu_err`/`aux_err`=0.
  - `cpu_rdata`/`aux_rdata`=0.
  - `mem_addr`=0, `mem_writeData`=0, `mem_writeEnable`=0.
- Latency: request sampled at edge N (in IDLE) → ACCESS during cycle N..N+1 → `ack` high during cycle N+1..N+2.
- Throughput: one access per 3 cycles. With both requesters continuously active, grants strictly alternate and neither waits more than one other access.
- `mem_writeEnable` is high only during ACCESS. It is 0 in IDLE and RESP.
- `mem_addr`/`mem_writeData` hold their last ACCESS values in IDLE and RESP; they do not glitch back to 0.
- Reset asserted in any state: `mem_writeEnable` forced 0 in that same cycle (no write commits), and the next state is IDLE. No ack is issued for the aborted access.
- Reset asserted during RESP: the ack pulse visible in that cycle is allowed; all outputs are at reset values after the edge.

## Test plan
- CPU read only: mem word 2 = 15. `cpu_req`, `cpu_we`=0, `cpu_addr`=8 → `mem_addr`=8 in ACCESS; `cpu_ack`=1, `cpu_err`=0, `cpu_rdata`=15 exactly 2 cycles after the sampling edge.
- AUX write then CPU read: aux writes 0xDEAD_BEEF to addr 12. Exactly one `mem_writeEnable` cycle occurs. A following CPU read of addr 12 → `cpu_rdata`=0xDEAD_BEEF, and `aux_rdata` is unchanged (0).
- Simultaneous requests held for 4 accesses, first from reset → grant order CPU, AUX, CPU, AUX. Acks are 3 cycles apart, and ack is never asserted on both ports in the same cycle.
- Rejections: CPU write to addr 6 (misaligned) and AUX write to addr 256 (out of range, DEPTH_WORDS=64) → `mem_writeEnable` never high; `cpu_err`=1 and `aux_err`=1 with their acks; memory contents unchanged.
- Reset mid-write: assert `reset` during the ACCESS cycle of a CPU write of 7 to addr 0 → no write (word 0 stays 12), no `cpu_ack`, FSM in IDLE. After release, a CPU read of addr 0 → 12.

Source files
------------

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin arbiter/sequencer sharing one data-memory port between CPU and AUX
// Each access is IDLE -> ACCESS -> RESP; illegal addresses are rejected without touching memory.
module dmem_arbiter #(
  parameter int DEPTH_WORDS = 64,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_err,
  output logic [DATA_W-1:0] cpu_rdata,

  input  logic              aux_req,
  input  logic              aux_we,
  input  logic [31:0]       aux_addr,
  input  logic [DATA_W-1:0] aux_wdata,
  output logic              aux_ack,
  output logic              aux_err,
  output logic [DATA_W-1:0] aux_rdata,

  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_writeData,
  output logic              mem_writeEnable,
  input  logic [DATA_W-1:0] mem_read
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic        ID_CPU    = 1'b0;
  localparam logic        ID_AUX    = 1'b1;
  localparam logic [31:0] DEPTH_W32 = 32'(DEPTH_WORDS);

  state_t              state_q, state_d;
  logic                last_q, last_d;
  logic                id_q, id_d;
  logic                we_q, we_d;
  logic                ok_q, ok_d;
  logic [31:0]         addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   aux_rdata_q, aux_rdata_d;

  logic                pick;
  logic                sel_we;
  logic [31:0]         sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  function automatic logic addr_legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && ({2'b00, a[31:2]} < DEPTH_W32);
  endfunction

  // Tie goes to whoever was not served last; a lone requester always wins.
  always_comb begin
    pick = ID_CPU;
    if (cpu_req && aux_req) begin
      pick = ~last_q;
    end else if (aux_req) begin
      pick = ID_AUX;
    end
    sel_we    = (pick == ID_AUX) ? aux_we    : cpu_we;
    sel_addr  = (pick == ID_AUX) ? aux_addr  : cpu_addr;
    sel_wdata = (pick == ID_AUX) ? aux_wdata : cpu_wdata;
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    id_d        = id_q;
    we_d        = we_q;
    ok_d        = ok_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    aux_rdata_d = aux_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (cpu_req || aux_req) begin
          id_d    = pick;
          we_d    = sel_we;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          ok_d    = addr_legal(sel_addr);
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (!we_q && ok_q) begin
          if (id_q == ID_AUX) begin
            aux_rdata_d = mem_read;
          end else begin
            cpu_rdata_d = mem_read;
          end
        end
        last_d  = id_q;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      last_q      <= ID_AUX;
      id_q        <= ID_CPU;
      we_q        <= 1'b0;
      ok_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      aux_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      id_q        <= id_d;
      we_q        <= we_d;
      ok_q        <= ok_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      aux_rdata_q <= aux_rdata_d;
    end
  end

  // Reset gates the strobe combinationally so an aborted write never lands.
  assign mem_addr        = addr_q;
  assign mem_writeData   = wdata_q;
  assign mem_writeEnable = (state_q == ST_ACCESS) & we_q & ok_q & ~reset;

  assign cpu_ack   = (state_q == ST_RESP) && (id_q == ID_CPU);
  assign aux_ack   = (state_q == ST_RESP) && (id_q == ID_AUX);
  assign cpu_err   = cpu_ack & ~ok_q;
  assign aux_err   = aux_ack & ~ok_q;
  assign cpu_rdata = cpu_rdata_q;
  assign aux_rdata = aux_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed bench for dmem_arbiter with a transaction-level reference model
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic        cpu_ack, cpu_err;
  logic [31:0] cpu_rdata;
  logic        aux_req = 1'b0, aux_we = 1'b0;
  logic [31:0] aux_addr = '0, aux_wdata = '0;
  logic        aux_ack, aux_err;
  logic [31:0] aux_rdata;
  logic [31:0] mem_addr, mem_writeData, mem_read;
  logic        mem_writeEnable;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int we_cnt = 0;

  dmem_arbiter #(.DEPTH_WORDS(64), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_ack(aux_ack), .aux_err(aux_err), .aux_rdata(aux_rdata),
    .mem_addr(mem_addr), .mem_writeData(mem_writeData),
    .mem_writeEnable(mem_writeEnable), .mem_read(mem_read)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    if (i == 0) return 32'd12;
    if (i == 2) return 32'd15;
    return 32'(i) * 32'h0101_0101;
  endfunction

  // Memory attached to the DUT port
  logic [31:0] mem [64];
  logic        mem_init = 1'b0;
  assign mem_read = (mem_addr[31:2] < 30'd64) ? mem[mem_addr[7:2]] : 32'hBAD0_BAD0;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
      mem_init <= 1'b1;
    end else if (mem_writeEnable && mem_addr[31:2] < 30'd64) begin
      mem[mem_addr[7:2]] <= mem_writeData;
    end
  end

  // Reference model: one transaction at a time, phase 0 idle, 1 memory access, 2 response
  logic [31:0] ref_mem [64];
  logic        ref_init = 1'b0;
  logic        m_started = 1'b0;
  int          m_phase = 0;
  bit          m_last = 1'b1;
  bit          m_win = 1'b0;
  bit          m_we = 1'b0;
  bit          m_ok = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_cpu_rd = '0, m_aux_rd = '0;

  always @(posedge clk) begin
    if (!ref_init) begin
      for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
      ref_init = 1'b1;
    end
    if (reset) begin
      m_phase = 0; m_last = 1'b1; m_addr = '0; m_wdata = '0;
      m_cpu_rd = '0; m_aux_rd = '0; m_started = 1'b1;
    end else if (m_phase == 0) begin
      if (cpu_req || aux_req) begin
        m_win   = (cpu_req && aux_req) ? !m_last : aux_req;
        m_we    = m_win ? aux_we : cpu_we;
        m_addr  = m_win ? aux_addr : cpu_addr;
        m_wdata = m_win ? aux_wdata : cpu_wdata;
        m_ok    = (m_addr % 4 == 0) && (m_addr / 4 < 64);
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (m_ok) begin
        if (m_we) ref_mem[m_addr / 4] = m_wdata;
        else if (m_win) m_aux_rd = ref_mem[m_addr / 4];
        else m_cpu_rd = ref_mem[m_addr / 4];
      end
      m_last  = m_win;
      m_phase = 2;
    end else begin
      m_phase = 0;
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      chk1("mem_we", mem_writeEnable, (m_phase == 1) && m_we && m_ok && !reset);
      chk32("mem_addr", mem_addr, m_addr);
      chk32("mem_wdata", mem_writeData, m_wdata);
      chk1("cpu_ack", cpu_ack, (m_phase == 2) && !m_win);
      chk1("aux_ack", aux_ack, (m_phase == 2) && m_win);
      chk1("cpu_err", cpu_err, (m_phase == 2) && !m_win && !m_ok);
      chk1("aux_err", aux_err, (m_phase == 2) && m_win && !m_ok);
      chk32("cpu_rdata", cpu_rdata, m_cpu_rd);
      chk32("aux_rdata", aux_rdata, m_aux_rd);
      chk1("ack_excl", cpu_ack & aux_ack, 1'b0);
    end
    if (mem_writeEnable) we_cnt++;
  end

  task automatic access(input bit port, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rd,
                        output logic err, output int lat, output logic [31:0] acc_addr);
    int  t0;
    bit  got;
    @(posedge clk); #1;
    if (port) begin
      aux_req = 1'b1; aux_we = we; aux_addr = addr; aux_wdata = wdata;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    end
    t0 = cyc;
    got = 1'b0;
    acc_addr = '0;
    rd = '0; err = 1'b0; lat = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if ((port ? aux_ack : cpu_ack) === 1'b1) begin
        got = 1'b1;
        rd  = port ? aux_rdata : cpu_rdata;
        err = port ? aux_err : cpu_err;
        lat = cyc - t0;
      end else begin
        acc_addr = mem_addr;
      end
    end
    chk1("ack_timeout", got, 1'b1);
    @(posedge clk); #1;
    if (port) aux_req = 1'b0; else cpu_req = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  logic [31:0] rd, aa;
  logic        er;
  int          lat, w0, nack;
  int          ack_who [4];
  int          ack_cyc [4];
  bit          ack_both;

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk32("rst_mem_addr", mem_addr, 32'd0);
    chk32("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk1("rst_cpu_ack", cpu_ack, 1'b0);
    chk1("rst_mem_we", mem_writeEnable, 1'b0);
    @(posedge clk); #1 reset = 1'b0;

    // CPU read of word 2
    access(1'b0, 1'b0, 32'd8, 32'd0, rd, er, lat, aa);
    chk32("t1_rdata", rd, 32'd15);
    chk1("t1_err", er, 1'b0);
    chk32("t1_latency", 32'(lat), 32'd2);
    chk32("t1_mem_addr", aa, 32'd8);

    // AUX write then CPU read of the same word
    w0 = we_cnt;
    access(1'b1, 1'b1, 32'd12, 32'hDEAD_BEEF, rd, er, lat, aa);
    chk1("t2_aux_err", er, 1'b0);
    chk32("t2_we_cycles", 32'(we_cnt - w0), 32'd1);
    access(1'b0, 1'b0, 32'd12, 32'd0, rd, er, lat, aa);
    chk32("t2_cpu_rdata", rd, 32'hDEAD_BEEF);
    chk32("t2_aux_rdata", aux_rdata, 32'd0);

    // Both requesters held from reset: alternating grants, CPU first
    do_reset();
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd4;
    aux_req = 1'b1; aux_we = 1'b0; aux_addr = 32'd8;
    nack = 0;
    ack_both = 1'b0;
    for (int k = 0; k < 20 && nack < 4; k++) begin
      @(negedge clk);
      if (cpu_ack && aux_ack) ack_both = 1'b1;
      if (cpu_ack || aux_ack) begin
        ack_who[nack] = aux_ack ? 1 : 0;
        ack_cyc[nack] = cyc;
        nack++;
      end
    end
    @(posedge clk); #1;
    cpu_req = 1'b0; aux_req = 1'b0;
    chk32("t3_ack_count", 32'(nack), 32'd4);
    chk1("t3_both_acked", ack_both, 1'b0);
    if (nack == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk32("t3_order", 32'(ack_who[i]), 32'(i % 2));
        if (i > 0) chk32("t3_spacing", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd3);
      end
    end
    chk32("t3_cpu_rdata", cpu_rdata, 32'h0101_0101);
    chk32("t3_aux_rdata", aux_rdata, 32'd15);

    // Rejected accesses
    w0 = we_cnt;
    access(1'b0, 1'b1, 32'd6, 32'h1111_1111, rd, er, lat, aa);
    chk1("t4_cpu_err", er, 1'b1);
    access(1'b1, 1'b1, 32'd256, 32'h2222_2222, rd, er, lat, aa);
    chk1("t4_aux_err", er, 1'b1);
    chk32("t4_we_cycles", 32'(we_cnt - w0), 32'd0);
    chk32("t4_word1", mem[1], 32'h0101_0101);

    // Reset during the ACCESS cycle of a CPU write
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'd0; cpu_wdata = 32'd7;
    @(posedge clk); #1;
    reset = 1'b1; cpu_req = 1'b0;
    @(negedge clk);
    chk1("t5_we_in_reset", mem_writeEnable, 1'b0);
    @(posedge clk); #1 reset = 1'b0;
    nack = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (cpu_ack) nack++;
    end
    chk32("t5_no_ack", 32'(nack), 32'd0);
    chk32("t5_word0", mem[0], 32'd12);
    access(1'b0, 1'b0, 32'd0, 32'd0, rd, er, lat, aa);
    chk32("t5_read0", rd, 32'd12);

    for (int i = 0; i < 64; i++) chk32("final_mem", mem[i], ref_mem[i]);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
